// File: rtl/irq_request_latch_pkg.sv
// ---------------------------------------------------------------------------
// irq_pkg
//   Shared definitions for the interrupt request-capture stage that feeds the
//   8-to-3 priority encoder.
//   Contents:
//     PKG_WIDTH / PKG_IDX_W : request-vector width and encoder index width
//     state_t               : presentation FSM state encoding
//     idx_to_onehot()       : decode of an acknowledged index into a bit mask
// ---------------------------------------------------------------------------
package irq_pkg;

   localparam int PKG_WIDTH = 8;
   localparam int PKG_IDX_W = 3;

   // IDLE   : nothing presented, waiting for a masked pending bit
   // BUSY   : snapshot frozen on req_vec/req_en, waiting for the acknowledge
   // SETTLE : one quiet cycle so the cleared pending bit is visible to IDLE
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_BUSY   = 2'd1,
      ST_SETTLE = 2'd2
   } state_t;

   function automatic logic [PKG_WIDTH-1:0] idx_to_onehot(
      input logic [PKG_IDX_W-1:0] idx
   );
      logic [PKG_WIDTH-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

endpackage

// File: rtl/irq_request_latch_sync.sv
// ---------------------------------------------------------------------------
// irq_sync
//   WIDTH-wide, STAGES-deep flop chain bringing asynchronous request lines
//   into the clk domain. Each bit is synchronised independently; no
//   cross-bit coherence is implied.
//   Ports:
//     clk    : sampling clock, rising edge
//     rst_n  : asynchronous active-low reset, clears every stage
//     i_d    : raw asynchronous inputs
//     o_q    : synchronised outputs (i_d delayed by STAGES flops)
// ---------------------------------------------------------------------------
module irq_sync #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [STAGES-1:0][WIDTH-1:0] r_stage;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stage <= '0;
      end else begin
         r_stage[0] <= i_d;
         for (int s = 1; s < STAGES; s++) begin
            r_stage[s] <= r_stage[s-1];
         end
      end
   end

   assign o_q = r_stage[STAGES-1];

endmodule

// File: rtl/irq_request_latch.sv
// ---------------------------------------------------------------------------
// irq_request_latch
//   Request-capture stage in front of the 8-to-3 priority encoder. Raw
//   request lines are synchronised, turned into sticky pending bits (edge or
//   level per bit), and a masked snapshot is presented to the encoder until
//   the consumer acknowledges the encoded index.
//
//   Handshake: req_en=1 means req_vec is a frozen, valid snapshot. It stays
//   frozen until a cycle with ack_valid=1 and req_vec[ack_idx]=1; that cycle
//   clears pending[ack_idx] and req_en/req_vec read 0 from the next cycle.
//   Any other ack_valid cycle is rejected with a one-cycle ack_err pulse.
//
//   Ports:
//     clk, rst_n  : clock (rising edge) and async active-low reset
//     irq_in      : raw asynchronous request lines
//     edge_mode   : per bit 1 = rising-edge triggered, 0 = level triggered
//     mask        : per bit 1 = allowed into a snapshot
//     req_vec     : snapshot of masked pending bits (encoder i)
//     req_en      : snapshot valid (encoder en)
//     ack_valid   : single-cycle acknowledge strobe
//     ack_idx     : acknowledged index (encoder y returned by the consumer)
//     ack_err     : one-cycle pulse on a rejected acknowledge
//     ovf         : sticky per-bit overflow (edge arrived while still pending)
//     ovf_clr     : clears all ovf bits
//     dbg_state   : current presentation FSM state
// ---------------------------------------------------------------------------
module irq_request_latch
   import irq_pkg::*;
#(
   parameter int WIDTH       = PKG_WIDTH,
   parameter int IDX_W       = PKG_IDX_W,
   parameter int SYNC_STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] irq_in,
   input  logic [WIDTH-1:0] edge_mode,
   input  logic [WIDTH-1:0] mask,
   output logic [WIDTH-1:0] req_vec,
   output logic             req_en,
   input  logic             ack_valid,
   input  logic [IDX_W-1:0] ack_idx,
   output logic             ack_err,
   output logic [WIDTH-1:0] ovf,
   input  logic             ovf_clr,
   output state_t           dbg_state
);

   generate
      if (WIDTH != (1 << IDX_W)) begin : g_bad_width
         $error("irq_request_latch: WIDTH must equal 2**IDX_W");
      end
      if (SYNC_STAGES < 2) begin : g_bad_sync
         $error("irq_request_latch: SYNC_STAGES must be at least 2");
      end
      if (WIDTH != PKG_WIDTH || IDX_W != PKG_IDX_W) begin : g_bad_pkg
         $error("irq_request_latch: WIDTH/IDX_W must match irq_pkg");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Synchronisation and edge detection
   // ------------------------------------------------------------------
   logic [WIDTH-1:0] w_sync;
   logic [WIDTH-1:0] r_sync_prev;
   logic [WIDTH-1:0] w_rise;
   logic [WIDTH-1:0] w_set;

   irq_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .i_d   (irq_in),
      .o_q   (w_sync)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync_prev <= '0;
      end else begin
         r_sync_prev <= w_sync;
      end
   end

   assign w_rise = w_sync & ~r_sync_prev;
   assign w_set  = (edge_mode & w_rise) | (~edge_mode & w_sync);

   // ------------------------------------------------------------------
   // Acknowledge decode
   // ------------------------------------------------------------------
   state_t           r_state;
   logic [WIDTH-1:0] r_req_vec;
   logic             r_req_en;
   logic             r_ack_err;
   logic [WIDTH-1:0] r_pending;
   logic [WIDTH-1:0] r_ovf;

   logic             w_ack_hit;
   logic [WIDTH-1:0] w_clr;
   logic [WIDTH-1:0] w_present;

   // Only an acknowledge naming a bit of the frozen snapshot is honoured.
   assign w_ack_hit = ack_valid && (r_state == ST_BUSY) && r_req_vec[ack_idx];
   assign w_clr     = w_ack_hit ? idx_to_onehot(ack_idx) : '0;
   assign w_present = r_pending & mask;

   // ------------------------------------------------------------------
   // Pending and overflow state
   // ------------------------------------------------------------------
   // Set has priority over clear, so a level bit that is still asserted, or
   // a fresh edge landing on the acknowledge cycle, is never lost.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pending <= '0;
         r_ovf     <= '0;
      end else begin
         r_pending <= w_set | (r_pending & ~w_clr);
         r_ovf     <= (edge_mode & w_rise & r_pending)
                    | (r_ovf & ~{WIDTH{ovf_clr}});
      end
   end

   // ------------------------------------------------------------------
   // Presentation FSM (all encoder-facing outputs registered here)
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_req_vec <= '0;
         r_req_en  <= 1'b0;
         r_ack_err <= 1'b0;
      end else begin
         r_ack_err <= ack_valid && !w_ack_hit;
         case (r_state)
            ST_IDLE: begin
               if (w_present != '0) begin
                  r_req_vec <= w_present;
                  r_req_en  <= 1'b1;
                  r_state   <= ST_BUSY;
               end else begin
                  r_req_vec <= '0;
                  r_req_en  <= 1'b0;
               end
            end
            ST_BUSY: begin
               // Snapshot held untouched until a valid acknowledge.
               if (w_ack_hit) begin
                  r_req_vec <= '0;
                  r_req_en  <= 1'b0;
                  r_state   <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               r_req_vec <= '0;
               r_req_en  <= 1'b0;
               r_state   <= ST_IDLE;
            end
            default: begin
               r_req_vec <= '0;
               r_req_en  <= 1'b0;
               r_state   <= ST_IDLE;
            end
         endcase
      end
   end

   assign req_vec   = r_req_vec;
   assign req_en    = r_req_en;
   assign ack_err   = r_ack_err;
   assign ovf       = r_ovf;
   assign dbg_state = r_state;

endmodule

// File: doc/irq_request_latch.md
Name: irq_request_latch

Overview:
- Upstream request-capture stage for the 8-to-3 priority encoder.
- Synchronises 8 asynchronous request lines and detects edges or levels per bit, holding them as sticky pending bits.
- Presents a stable, masked snapshot vector plus enable to the encoder, then clears the serviced bit when the consumer acknowledges the encoded index.
- req_vec drives the encoder i input; req_en drives its en input.

Parameters:
- WIDTH, 8, number of request lines; must equal 2**IDX_W.
- IDX_W, 3, index width of ack_idx; matches the encoder output width.
- SYNC_STAGES, 2, synchroniser flops per request line; minimum 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- irq_in  input  WIDTH  raw asynchronous request lines.
- edge_mode  input  WIDTH  per bit: 1 = rising-edge triggered, 0 = level triggered; quasi-static.
- mask  input  WIDTH  per bit: 1 = enabled for presentation.
- req_vec  output  WIDTH  snapshot of masked pending bits; to encoder i.
- req_en  output  1  snapshot valid; to encoder en.
- ack_valid  input  1  single-cycle acknowledge strobe.
- ack_idx  input  IDX_W  index being acknowledged (encoder y, returned by consumer).
- ack_err  output  1  one-cycle pulse on an invalid acknowledge.
- ovf  output  WIDTH  sticky per-bit overflow flags.
- ovf_clr  input  1  clears all ovf bits.

Behaviour:
- Reset (async assert, sync-free release): sync flops, edge history, pending, req_vec, ovf all 0; req_en=0; ack_err=0; FSM=IDLE. Reset mid-BUSY discards the snapshot and all pending bits.
- Sync: s = irq_in delayed by SYNC_STAGES flops. Edge detect: rise = s & ~s_prev.
- Set term per bit: edge_mode ? rise : s.
- pending[b] next = set[b] | (pending[b] & ~clr[b]), where clr[b] = valid ack of index b. When set and clear coincide on the same bit, set wins.
- Level-mode bit still high after ack re-pends on the next cycle. This is intended.
- ovf[b] sets when an edge-mode rise occurs while pending[b]=1. It clears on ovf_clr. If the set and ovf_clr coincide, set wins.
- FSM states:
  - IDLE: req_en=0, req_vec=0. If (pending & mask) != 0, capture req_vec <= pending & mask, set req_en=1, go to BUSY.
  - BUSY: req_vec and req_en held constant regardless of mask, irq_in or pending changes.
    - ack_valid with req_vec[ack_idx]=1: clear pending[ack_idx], drop req_en and req_vec to 0 next cycle, go to SETTLE.
    - ack_valid with req_vec[ack_idx]=0: ack_err pulse, no clear, stay in BUSY.
  - SETTLE: one cycle, outputs 0, so the pending update is visible; then go to IDLE.
- ack_valid in IDLE or SETTLE: ignored, ack_err pulses for 1 cycle.
- Latency: irq_in high before edge 0 gives pending=1 after edge SYNC_STAGES and req_en=1 after edge SYNC_STAGES+1 (edge 3 at default).
- Back-to-back minimum: ack at edge n, req_en low after edge n; next snapshot can present after edge n+2.
- All outputs are registered. req_vec is never nonzero while req_en=0, so the encoder never sees i!=0 with en=0.

Decomposition:
- Shared package irq_pkg holds:
  - WIDTH and IDX_W constants.
  - FSM state typedef: IDLE, BUSY, SETTLE.
  - ack_idx-to-one-hot decode function.
- Sub-module irq_sync: a WIDTH-wide, SYNC_STAGES-deep synchroniser with async active-low reset. It is the only instance.

Test Plan:
- Edge mode: edge_mode=FF, mask=FF, pulse irq_in[5] for 1 cycle -> req_en=1, req_vec=8'h20 after edge 3. Then ack_idx=5 -> req_vec=0, req_en=0 next cycle; no re-request.
- Level mode: edge_mode=00, mask=FF, hold irq_in=8'h81 -> req_vec=8'h81. Ack 7 -> after SETTLE, req_vec=8'h81 again because both levels are still high. Drop irq_in[7], then ack 7 -> req_vec=8'h01.
- Snapshot stability: in BUSY with req_vec=8'h04, assert irq_in[6] edge and set mask=00 -> req_vec stays 8'h04 until ack 2. After SETTLE with mask=FF -> req_vec=8'h40.
- Invalid ack: req_vec=8'h10, ack_idx=3 -> ack_err 1-cycle pulse, req_vec remains 8'h10. Ack in IDLE -> ack_err pulse, no state change.
- Overflow/simultaneity: bit 2 pending, second edge on irq_in[2] -> ovf=8'h04. A rise on bit 1 coinciding with ack 1 -> pending[1] stays 1. ovf_clr -> ovf=0.
- Reset mid-op: rst_n low during BUSY with req_vec=8'hF0 -> req_en, req_vec, ovf=0 immediately (async). After release with irq_in=0 -> stays IDLE.
